// File: rtl/cache_controller_if.sv
// CPU request, mapping-stage, main-memory and data-array signals
// of the direct-mapped cache controller; slave = controller side.
interface cache_controller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCKS_NUM = 8
);
    localparam int IW = $clog2(BLOCKS_NUM);
    localparam int BW = IW + 2;

    logic                  rd_req;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [IW-1:0]         tag_index;
    logic [BW-1:0]         block_index;
    logic [1:0]            word_offset;
    logic [ADDR_WIDTH-1:0] block_addr;
    logic                  hit;
    logic                  stall;
    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;
    logic                  cache_we;
    logic [BW-1:0]         cache_waddr;
    logic [DATA_WIDTH-1:0] cache_wdata;

    modport slave (
        input  rd_req, wr_req, addr, wr_data,
        input  tag_index, block_index, word_offset, block_addr,
        input  mem_rdata, mem_ready,
        output hit, stall, mem_rd_en, mem_wr_en,
        output mem_addr, mem_wdata,
        output cache_we, cache_waddr, cache_wdata
    );

    modport master (
        output rd_req, wr_req, addr, wr_data,
        output tag_index, block_index, word_offset, block_addr,
        output mem_rdata, mem_ready,
        input  hit, stall, mem_rd_en, mem_wr_en,
        input  mem_addr, mem_wdata,
        input  cache_we, cache_waddr, cache_wdata
    );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped cache control FSM: 4-word read-miss refill,
// write-through no-write-allocate stores, tag/valid arrays.
// Ports: clk, rst_n (async, active low), bus (cache_controller_if.slave).
module cache_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCKS_NUM = 8
) (
    input logic               clk,
    input logic               rst_n,
    cache_controller_if.slave bus
);
    localparam int IW = $clog2(BLOCKS_NUM);
    localparam int BW = IW + 2;
    localparam int TW = ADDR_WIDTH - BW;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        WDONE
    } state_t;

    state_t state, state_nx;

    logic [1:0]            cnt;
    logic [BLOCKS_NUM-1:0] valid;
    logic [TW-1:0]         tag [BLOCKS_NUM];

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] blk_addr_q;
    logic [BW-1:0]         bidx_q;
    logic [IW-1:0]         ti_q;
    logic [1:0]            wo_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  hit_q;

    logic [TW-1:0] req_tag;
    logic          hit;
    logic          take;
    logic          last;

    assign req_tag = bus.addr[ADDR_WIDTH-1 -: TW];
    assign hit     = valid[bus.tag_index] &&
                     (tag[bus.tag_index] == req_tag);
    assign bus.hit = hit;

    // A request is taken (and latched) on a store or a load miss.
    assign take = bus.wr_req || (bus.rd_req && !hit);
    assign last = bus.mem_ready && (cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.wr_req) begin
                    state_nx = WRITE;
                end else if (bus.rd_req && !hit) begin
                    state_nx = REFILL;
                end
            end
            REFILL: begin
                if (last) begin
                    state_nx = IDLE;
                end
            end
            WRITE: begin
                if (bus.mem_ready) begin
                    state_nx = WDONE;
                end
            end
            WDONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Everything is forced low while reset is held, including the
    // IDLE stall that would otherwise follow a pending request.
    always_comb begin
        bus.stall       = 1'b0;
        bus.mem_rd_en   = 1'b0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.cache_we    = 1'b0;
        bus.cache_waddr = '0;
        bus.cache_wdata = '0;
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    bus.stall = take;
                end
                REFILL: begin
                    bus.stall     = 1'b1;
                    bus.mem_rd_en = 1'b1;
                    bus.mem_addr  = blk_addr_q + ADDR_WIDTH'(cnt);
                    if (bus.mem_ready) begin
                        bus.cache_we    = 1'b1;
                        bus.cache_waddr = bidx_q + BW'(cnt);
                        bus.cache_wdata = bus.mem_rdata;
                    end
                end
                WRITE: begin
                    bus.stall     = 1'b1;
                    bus.mem_wr_en = 1'b1;
                    bus.mem_addr  = addr_q;
                    bus.mem_wdata = wdata_q;
                    if (bus.mem_ready && hit_q) begin
                        bus.cache_we    = 1'b1;
                        bus.cache_waddr = bidx_q + BW'(wo_q);
                        bus.cache_wdata = wdata_q;
                    end
                end
                WDONE: begin
                    bus.stall = 1'b0;
                end
                default: begin
                    bus.stall = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            valid      <= '0;
            addr_q     <= '0;
            blk_addr_q <= '0;
            bidx_q     <= '0;
            ti_q       <= '0;
            wo_q       <= '0;
            wdata_q    <= '0;
            hit_q      <= 1'b0;
            for (int i = 0; i < BLOCKS_NUM; i++) begin
                tag[i] <= '0;
            end
        end else begin
            if (state == IDLE && take) begin
                cnt        <= '0;
                addr_q     <= bus.addr;
                blk_addr_q <= bus.block_addr;
                bidx_q     <= bus.block_index;
                ti_q       <= bus.tag_index;
                wo_q       <= bus.word_offset;
                wdata_q    <= bus.wr_data;
                hit_q      <= hit;
            end
            if (state == REFILL && bus.mem_ready) begin
                cnt <= cnt + 2'd1;
            end
            // Tag/valid are only committed with the final word, so an
            // interrupted refill never leaves a half-filled valid block.
            if (state == REFILL && last) begin
                valid[ti_q] <= 1'b1;
                tag[ti_q]   <= addr_q[ADDR_WIDTH-1 -: TW];
            end
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: directed loads, stores,
// conflicts, slow memory and reset abort.
module tb_cache_controller;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;
    int wait_n   = 0;
    int waited   = 0;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] data;
    } cexp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } mexp_t;

    cexp_t cq[$];
    mexp_t mq[$];

    cache_controller_if #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .BLOCKS_NUM(8)
    ) ifc ();

    cache_controller #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .BLOCKS_NUM(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content model: each word is a function of its address.
    always_comb ifc.mem_rdata = 32'hA500_0000 ^ ifc.mem_addr;

    // Memory responder: ready always, or after wait_n idle cycles.
    always @(posedge clk) begin
        #1;
        if (wait_n == 0) begin
            ifc.mem_ready = 1'b1;
        end else if (ifc.mem_rd_en || ifc.mem_wr_en) begin
            if (waited < wait_n) begin
                ifc.mem_ready = 1'b0;
                waited++;
            end else begin
                ifc.mem_ready = 1'b1;
                waited = 0;
            end
        end else begin
            ifc.mem_ready = 1'b0;
            waited = 0;
        end
    end

    // Monitor: pops expectations when the DUT shows a transfer.
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        cexp_t ce;
        mexp_t me;
        if (rst_n) begin
            if (ifc.cache_we) begin
                n_checks++;
                if (cq.size() == 0) begin
                    n_fail++;
                    $display("FAIL cache_we_unexpected got waddr=%0h data=%h expected none",
                             ifc.cache_waddr, ifc.cache_wdata);
                end else begin
                    ce = cq.pop_front();
                    if (ifc.cache_waddr !== ce.waddr || ifc.cache_wdata !== ce.data) begin
                        n_fail++;
                        $display("FAIL cache_write got waddr=%0h data=%h expected waddr=%0h data=%h",
                                 ifc.cache_waddr, ifc.cache_wdata, ce.waddr, ce.data);
                    end
                end
            end
            if ((ifc.mem_rd_en || ifc.mem_wr_en) && ifc.mem_ready) begin
                n_checks++;
                if (mq.size() == 0) begin
                    n_fail++;
                    $display("FAIL mem_unexpected got rd=%b wr=%b addr=%h expected none",
                             ifc.mem_rd_en, ifc.mem_wr_en, ifc.mem_addr);
                end else begin
                    me = mq.pop_front();
                    if (ifc.mem_wr_en !== me.wr || ifc.mem_rd_en !== !me.wr ||
                        ifc.mem_addr !== me.addr ||
                        (me.wr && ifc.mem_wdata !== me.data)) begin
                        n_fail++;
                        $display("FAIL mem_xfer got wr=%b rd=%b addr=%h wdata=%h expected wr=%b addr=%h wdata=%h",
                                 ifc.mem_wr_en, ifc.mem_rd_en, ifc.mem_addr, ifc.mem_wdata,
                                 me.wr, me.addr, me.data);
                    end
                end
            end
            if (prev_pend && (ifc.mem_rd_en || ifc.mem_wr_en)) begin
                n_checks++;
                if (ifc.mem_addr !== prev_addr) begin
                    n_fail++;
                    $display("FAIL mem_addr_stable got %h expected %h", ifc.mem_addr, prev_addr);
                end
            end
            prev_pend = (ifc.mem_rd_en || ifc.mem_wr_en) && !ifc.mem_ready;
            prev_addr = ifc.mem_addr;
        end else begin
            prev_pend = 1'b0;
        end
    end

    task automatic set_map(input logic [31:0] a);
        ifc.addr        = a;
        ifc.tag_index   = a[4:2];
        ifc.block_index = {a[4:2], 2'b00};
        ifc.word_offset = a[1:0];
        ifc.block_addr  = {a[31:2], 2'b00};
    endtask

    task automatic exp_refill(input logic [31:0] a, input int words);
        logic [31:0] ba;
        logic [4:0]  bi;
        ba = {a[31:2], 2'b00};
        bi = {a[4:2], 2'b00};
        for (int i = 0; i < words; i++) begin
            mq.push_back('{1'b0, ba + 32'(i), 32'h0});
            cq.push_back('{bi + 5'(i), 32'hA500_0000 ^ (ba + 32'(i))});
        end
    endtask

    task automatic exp_store(input logic [31:0] a, input logic [31:0] d,
                             input bit is_hit);
        logic [4:0] wa;
        wa = {a[4:2], a[1:0]};
        mq.push_back('{1'b1, a, d});
        if (is_hit) cq.push_back('{wa, d});
    endtask

    task automatic check_zero(input string name);
        logic [135:0] all;
        all = {ifc.hit, ifc.stall, ifc.mem_rd_en, ifc.mem_wr_en,
               ifc.mem_addr, ifc.mem_wdata, ifc.cache_we,
               ifc.cache_waddr, ifc.cache_wdata};
        n_checks++;
        if (all !== '0) begin
            n_fail++;
            $display("FAIL %s got outputs=%h expected 0", name, all);
        end
    endtask

    // Issues one request at posedge+1 and counts stalled cycles.
    task automatic do_req(input string name, input logic [31:0] a,
                          input bit rd, input bit wr,
                          input logic [31:0] d, input int exp_stall);
        int n;
        bit tmo;
        n   = 0;
        tmo = 1'b0;
        set_map(a);
        ifc.wr_data = d;
        ifc.rd_req  = rd;
        ifc.wr_req  = wr;
        forever begin
            @(negedge clk);
            if (!ifc.stall) break;
            n++;
            if (n > 60) begin
                tmo = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (tmo || n != exp_stall) begin
            n_fail++;
            $display("FAIL %s_stall got %0d cycles (timeout=%0b) expected %0d",
                     name, n, tmo, exp_stall);
        end
        if (rd && !wr) begin
            n_checks++;
            if (ifc.hit !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_hit got %b expected 1", name, ifc.hit);
            end
        end
        @(posedge clk);
        #1;
        ifc.rd_req = 1'b0;
        ifc.wr_req = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        ifc.rd_req    = 1'b0;
        ifc.wr_req    = 1'b0;
        ifc.wr_data   = '0;
        ifc.mem_ready = 1'b1;
        set_map(32'h0);
        @(negedge clk);
        check_zero("reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("idle_after_reset");
        @(posedge clk);
        #1;

        exp_refill(32'h40, 4);
        do_req("miss_40", 32'h40, 1'b1, 1'b0, 32'h0, 5);
        do_req("hit_41", 32'h41, 1'b1, 1'b0, 32'h0, 0);

        exp_refill(32'h60, 4);
        do_req("conflict_60", 32'h60, 1'b1, 1'b0, 32'h0, 5);
        exp_refill(32'h40, 4);
        do_req("remiss_40", 32'h40, 1'b1, 1'b0, 32'h0, 5);

        exp_store(32'h42, 32'hDEADBEEF, 1'b1);
        do_req("store_hit_42", 32'h42, 1'b0, 1'b1, 32'hDEADBEEF, 2);
        exp_store(32'h80, 32'h0BAD_F00D, 1'b0);
        do_req("store_miss_80", 32'h80, 1'b0, 1'b1, 32'h0BAD_F00D, 2);
        do_req("hit_40_kept", 32'h40, 1'b1, 1'b0, 32'h0, 0);

        wait_n = 2;
        exp_refill(32'h24, 4);
        do_req("slow_miss_24", 32'h24, 1'b1, 1'b0, 32'h0, 13);
        wait_n = 0;
        @(posedge clk);
        #1;
        do_req("hit_25", 32'h25, 1'b1, 1'b0, 32'h0, 0);

        // Abort a refill of 0x48 after its second word.
        exp_refill(32'h48, 2);
        set_map(32'h48);
        ifc.rd_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("reset_mid_refill");
        ifc.rd_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("idle_after_abort");
        @(posedge clk);
        #1;
        exp_refill(32'h48, 4);
        do_req("miss_48_again", 32'h48, 1'b1, 1'b0, 32'h0, 5);

        exp_refill(32'h40, 4);
        do_req("miss_40_post_rst", 32'h40, 1'b1, 1'b0, 32'h0, 5);
        exp_store(32'h43, 32'h1234_5678, 1'b1);
        do_req("rd_wr_both_43", 32'h43, 1'b1, 1'b1, 32'h1234_5678, 2);

        repeat (3) @(posedge clk);
        n_checks++;
        if (mq.size() != 0 || cq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got mem=%0d cache=%0d pending expected 0",
                     mq.size(), cq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
# cache_controller

Direct-mapped cache control FSM sitting directly downstream of the cache address-mapping stage. It consumes that stage's `tag_index`, `block_index`, `word_offset` and `block_addr` and owns the tag and valid arrays. It refills 4-word blocks from main memory on read misses and implements write-through, no-write-allocate stores. It drives the cache data array write port and the CPU stall.

## Interface
- `ADDR_WIDTH`, 32, address width (word addressing; bits [1:0] select a word in a block)
- `DATA_WIDTH`, 32, word width
- `BLOCKS_NUM`, 8, number of cache blocks (power of 2, ≥2)
- `clk`  in  1  the single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rd_req`  in  1  CPU load request, held until `stall`=0
- `wr_req`  in  1  CPU store request, held until `stall`=0
- `addr`  in  ADDR_WIDTH  CPU address (tag taken from bits [ADDR_WIDTH-1 : 2+log2(BLOCKS_NUM)])
- `wr_data`  in  DATA_WIDTH  store data
- `tag_index`  in  log2(BLOCKS_NUM)  from mapping stage
- `block_index`  in  log2(4*BLOCKS_NUM)  from mapping stage, word 0 of block
- `word_offset`  in  2  from mapping stage
- `block_addr`  in  ADDR_WIDTH  from mapping stage, block-aligned address
- `hit`  out  1  request address valid and tag-matched (combinational)
- `stall`  out  1  hold CPU pipeline
- `mem_rd_en`, `mem_wr_en`  out  1  main-memory read/write strobes
- `mem_addr`  out  ADDR_WIDTH  main-memory address
- `mem_wdata`  out  DATA_WIDTH  main-memory write data
- `mem_rdata`  in  DATA_WIDTH  main-memory read data, valid with `mem_ready`
- `mem_ready`  in  1  memory accepted write / returned read word this cycle
- `cache_we`  out  1  cache data array write enable
- `cache_waddr`  out  log2(4*BLOCKS_NUM)  cache data array word address
- `cache_wdata`  out  DATA_WIDTH  cache data array write data

## Operation
- State: `valid[BLOCKS_NUM]`, `tag[BLOCKS_NUM]`, FSM {IDLE, REFILL, WRITE, WDONE}, 2-bit refill counter `cnt`, latched `addr`/`block_addr`/`block_index`/`tag_index`/`word_offset`/`wr_data`/hit flag.
- `hit` = `valid[tag_index]` and `tag[tag_index]` equals the tag field of `addr`, evaluated in every state.
- IDLE: `wr_req` has priority over `rd_req`. On `wr_req`: latch request, `stall`=1, go to WRITE. On `rd_req` with hit: `stall`=0, no state change. On `rd_req` miss: latch, `stall`=1, `cnt`←0, go to REFILL.
- REFILL: `mem_rd_en`=1, `mem_addr`=latched `block_addr`+`cnt`. On `mem_ready`: `cache_we`=1, `cache_waddr`=latched `block_index`+`cnt`, `cache_wdata`=`mem_rdata`, `cnt`++. On `mem_ready` with `cnt`==3: `tag[ti]`←tag, `valid[ti]`←1, go to IDLE. The retried read then hits.
- WRITE: `mem_wr_en`=1, `mem_addr`=latched `addr`, `mem_wdata`=latched `wr_data`. On `mem_ready`: if the latched hit flag is set, `cache_we`=1, `cache_waddr`=`block_index`+`word_offset`, `cache_wdata`=`wr_data`; go to WDONE. A miss does not allocate.
- WDONE: `stall`=0 for exactly one cycle so the store retires without retriggering; go to IDLE.
- `stall`=1 in REFILL and WRITE and on the IDLE cycles described above; 0 otherwise.
- `mem_ready` is ignored in IDLE and WDONE.
- Index arithmetic is modulo its width; `block_index`+`cnt` never carries into the next block.

## Timing
- Reset (`rst_n`=0, asynchronous): state←IDLE, `cnt`←0, all `valid`←0. All outputs are 0 while `rst_n`=0. After reset, outputs remain 0 until a request arrives.
- Reset during REFILL or WRITE: the operation is abandoned and the partial block is never marked valid (tags are written only on the final word).
- Read hit: zero added latency, `stall` never asserts.
- Read miss with `mem_ready` held high: `stall`=1 for 5 cycles (detect cycle plus 4 refill cycles); hit on cycle 6. Each memory wait cycle adds one cycle.
- Store with `mem_ready` high: `stall`=1 for 2 cycles, then WDONE with `stall`=0.
- Memory handshake: strobe and address are held stable until the `mem_ready` cycle; at most one word transfers per cycle.

## Test plan
- Reset, then `rd_req` at `addr`=0x40 (`tag_index`=0) → miss; `mem_addr` sequence 0x40..0x43; `cache_waddr` 0..3; stall 5 cycles; then `hit`=1.
- Re-read 0x41 after the fill → `hit`=1, `stall`=0, no memory strobes.
- Conflict: read 0x60 (same index, different tag) → refill, then read 0x40 → misses again.
- Store hit to 0x42 with data 0xDEADBEEF → `mem_wr_en` until `mem_ready`, `cache_we` at `cache_waddr`=2, one WDONE cycle; store miss to 0x80 → no `cache_we`, `valid` unchanged.
- Refill with `mem_ready` low 2 cycles per word → stall 13 cycles, addresses held stable.
- `rst_n` pulsed low after the 2nd refill word → IDLE, outputs 0; subsequent read of the same address misses again; `rd_req`+`wr_req` together → write path taken.
